tero_scan_ctrl: RTL and testbench

//  Sequencer for the TERO-loop PUF measurement datapath.
//  - On start: walks all NUM_LOOPS TEROs in challenge-dependent pair order; drives loop select, enable and counter clear.
//  - Captures the external frequency-counter value for each loop.
//  - Compares counts pairwise to build a NUM_LOOPS/2-bit response word.
//  - Sits between the PUF top-level command logic and the TERO array / edge counter.

---
 rtl/tero_scan_ctrl.sv | 163 ++++++++++++++++
 tb/tb_tero_scan_ctrl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/tero_scan_ctrl.sv
// TERO-loop PUF scan sequencer. It walks every loop in challenge-rotated pair order,
// counts each loop over a fixed window, and turns the pairwise comparisons into a response word.
module tero_scan_ctrl #(
  parameter int NUM_LOOPS      = 32,
  parameter int CHALLENGE_BITS = 4,
  parameter int CNT_WIDTH      = 16,
  parameter int SETTLE_CYCLES  = 4,
  parameter int WINDOW_CYCLES  = 1024
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic [CHALLENGE_BITS-1:0]    challenge_in,
  input  logic [CNT_WIDTH-1:0]         cnt_value,
  output logic [$clog2(NUM_LOOPS)-1:0] tero_sel,
  output logic                         tero_en,
  output logic                         cnt_clear,
  output logic                         busy,
  output logic                         done,
  output logic [NUM_LOOPS/2-1:0]       response
);

  localparam int SELW   = $clog2(NUM_LOOPS);
  localparam int HALF   = NUM_LOOPS / 2;
  localparam int CYCMAX = (SETTLE_CYCLES > WINDOW_CYCLES) ? SETTLE_CYCLES : WINDOW_CYCLES;
  localparam int CYCW   = $clog2(CYCMAX + 1);

  localparam logic [CYCW-1:0] SETTLE_LAST = CYCW'(SETTLE_CYCLES - 1);
  localparam logic [CYCW-1:0] WINDOW_LAST = CYCW'(WINDOW_CYCLES - 1);
  localparam logic [SELW-1:0] STEP_LAST   = SELW'(NUM_LOOPS - 1);
  localparam logic [SELW:0]   NL          = (SELW+1)'(NUM_LOOPS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_MEASURE,
    S_CAPTURE,
    S_DONE
  } state_e;

  state_e                    state_q, state_d;
  logic [CHALLENGE_BITS-1:0] chal_q, chal_d;
  logic [SELW-1:0]           step_q, step_d;
  logic [CYCW-1:0]           cyc_q, cyc_d;
  logic [CNT_WIDTH-1:0]      cnt_a_q, cnt_a_d;
  logic [HALF-1:0]           shadow_q, shadow_d;
  logic [SELW-1:0]           sel_q, sel_d;
  logic                      en_q, en_d;
  logic                      clr_q, clr_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic [HALF-1:0]           resp_q, resp_d;

  logic [SELW-1:0]           off_w;
  logic [SELW:0]             sum_w;

  always_comb begin
    state_d  = state_q;
    chal_d   = chal_q;
    step_d   = step_q;
    cyc_d    = cyc_q;
    cnt_a_d  = cnt_a_q;
    shadow_d = shadow_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SELECT;
          chal_d  = challenge_in;
          step_d  = '0;
          cyc_d   = '0;
        end
      end
      S_SELECT: begin
        if (cyc_q == SETTLE_LAST) begin
          state_d = S_MEASURE;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + CYCW'(1);
        end
      end
      S_MEASURE: begin
        if (cyc_q == WINDOW_LAST) begin
          state_d = S_CAPTURE;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + CYCW'(1);
        end
      end
      S_CAPTURE: begin
        // Even step holds the first loop of a pair; odd step resolves the pair bit.
        if (!step_q[0]) cnt_a_d = cnt_value;
        else            shadow_d[step_q[SELW-1:1]] = (cnt_a_q > cnt_value);
        if (step_q == STEP_LAST) begin
          state_d = S_DONE;
        end else begin
          state_d = S_SELECT;
          step_d  = step_q + SELW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Loop index = (2*off + step) mod NUM_LOOPS; the sum stays below 2*NUM_LOOPS,
  // so one conditional subtract wraps it for any even loop count.
  always_comb begin
    off_w = SELW'(32'(chal_d) % HALF);
    sum_w = {off_w, 1'b0} + {1'b0, step_d};
    if (sum_w >= NL) sum_w = sum_w - NL;
  end

  // Outputs are registered decodes of the next state, so they change cleanly on the edge.
  always_comb begin
    sel_d  = sel_q;
    resp_d = resp_q;
    if (state_d == S_SELECT && state_q != S_SELECT) sel_d = sum_w[SELW-1:0];
    if (state_d == S_DONE) resp_d = shadow_d;
    en_d   = (state_d == S_MEASURE);
    clr_d  = (state_d == S_SELECT);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      chal_q   <= '0;
      step_q   <= '0;
      cyc_q    <= '0;
      cnt_a_q  <= '0;
      shadow_q <= '0;
      sel_q    <= '0;
      en_q     <= 1'b0;
      clr_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      resp_q   <= '0;
    end else begin
      state_q  <= state_d;
      chal_q   <= chal_d;
      step_q   <= step_d;
      cyc_q    <= cyc_d;
      cnt_a_q  <= cnt_a_d;
      shadow_q <= shadow_d;
      sel_q    <= sel_d;
      en_q     <= en_d;
      clr_q    <= clr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      resp_q   <= resp_d;
    end
  end

  assign tero_sel  = sel_q;
  assign tero_en   = en_q;
  assign cnt_clear = clr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign response  = resp_q;

endmodule

// File: tb/tb_tero_scan_ctrl.sv
// Directed bench for tero_scan_ctrl: a 4-loop array with a small settle/window so
// one scan is 45 cycles; the counter model returns a table entry for the selected loop.
module tb_tero_scan_ctrl;
  localparam int N   = 4;
  localparam int CB  = 2;
  localparam int CW  = 16;
  localparam int S   = 2;
  localparam int W   = 8;
  localparam int LAT = 45;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [CB-1:0] challenge_in = '0;
  logic [CW-1:0] cnt_value;
  logic [1:0]    tero_sel;
  logic          tero_en, cnt_clear, busy, done;
  logic [1:0]    response;

  logic [CW-1:0] counts [N];
  int vectors = 0;
  int miscompares = 0;

  tero_scan_ctrl #(
    .NUM_LOOPS(N), .CHALLENGE_BITS(CB), .CNT_WIDTH(CW),
    .SETTLE_CYCLES(S), .WINDOW_CYCLES(W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .challenge_in(challenge_in),
    .cnt_value(cnt_value), .tero_sel(tero_sel), .tero_en(tero_en),
    .cnt_clear(cnt_clear), .busy(busy), .done(done), .response(response)
  );

  always #5 clk = ~clk;
  assign cnt_value = counts[tero_sel];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_counts(input int c0, input int c1, input int c2, input int c3);
    counts[0] = CW'(c0); counts[1] = CW'(c1); counts[2] = CW'(c2); counts[3] = CW'(c3);
  endtask

  // One full scan; exp_order packs the expected loop order, first loop in the top bits.
  task automatic run_scan(input string nm, input logic [1:0] chal, input logic [1:0] exp_resp,
                          input logic [7:0] exp_order, input bit pulses);
    logic [1:0] resp0;
    logic [7:0] order;
    logic [1:0] prev_sel;
    bit prev_clr, prev_en, both, sel_moved, resp_moved, busy_drop, extra_done;
    int k;
    order = '0; prev_sel = '0; prev_clr = 0; prev_en = 0;
    both = 0; sel_moved = 0; resp_moved = 0; busy_drop = 0; extra_done = 0;
    @(negedge clk);
    start = 1'b1; challenge_in = chal; resp0 = response;
    @(posedge clk); #1;
    start = 1'b0; challenge_in = ~chal;
    k = 1;
    while (1) begin
      if (tero_en && cnt_clear) both = 1;
      if (cnt_clear && !prev_clr) order = {order[5:0], tero_sel};
      if (tero_en && prev_en && tero_sel != prev_sel) sel_moved = 1;
      if (!done && response !== resp0) resp_moved = 1;
      if (!busy) busy_drop = 1;
      prev_clr = cnt_clear; prev_en = tero_en; prev_sel = tero_sel;
      if (done || k >= 120) break;
      start = pulses && (k == 5 || k == 20);
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0;
    chk({nm, " latency"}, k, LAT);
    chk({nm, " done"}, done, 1);
    chk({nm, " response"}, response, exp_resp);
    chk({nm, " sel order"}, order, exp_order);
    chk({nm, " en+clr overlap"}, both, 0);
    chk({nm, " sel moved while en"}, sel_moved, 0);
    chk({nm, " response early"}, resp_moved, 0);
    chk({nm, " busy gap"}, busy_drop, 0);
    @(posedge clk); #1;
    chk({nm, " busy after"}, busy, 0);
    chk({nm, " done pulse"}, done, 0);
    repeat (4) begin
      @(posedge clk); #1;
      if (done || busy) extra_done = 1;
    end
    chk({nm, " second done"}, extra_done, 0);
    chk({nm, " response held"}, response, exp_resp);
  endtask

  initial begin
    bit seen;
    bit found;
    set_counts(100, 90, 50, 60);

    // Reset, then idle with no start.
    repeat (3) @(negedge clk);
    chk("rst tero_en", tero_en, 0);
    reset_n = 1'b1;
    seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1;
    end
    chk("idle activity", seen, 0);
    chk("idle tero_sel", tero_sel, 0);
    chk("idle tero_en", tero_en, 0);
    chk("idle cnt_clear", cnt_clear, 0);
    chk("idle busy", busy, 0);
    chk("idle done", done, 0);
    chk("idle response", response, 0);

    // chal 0: pairs (0,1)=100>90 -> 1, (2,3)=50>60 -> 0.
    run_scan("chal0", 2'd0, 2'b01, 8'h1B, 0);
    // chal 1: order 2,3,0,1; pair0 50>60 -> 0, pair1 100>90 -> 1.
    run_scan("chal1", 2'd1, 2'b10, 8'hB1, 0);
    set_counts(70, 70, 70, 70);
    run_scan("equal", 2'd0, 2'b00, 8'h1B, 0);
    // chal 3 folds to offset 1; extra start pulses mid-scan must be dropped.
    set_counts(100, 90, 50, 60);
    run_scan("pulses", 2'd3, 2'b10, 8'hB1, 1);
    run_scan("chal2", 2'd2, 2'b01, 8'h1B, 0);

    // Reset during MEASURE of loop 2.
    @(negedge clk);
    start = 1'b1; challenge_in = 2'd0;
    @(posedge clk); #1;
    start = 1'b0;
    found = 0;
    for (int i = 0; i < 100; i++) begin
      if (tero_sel == 2'd2 && tero_en) begin found = 1; break; end
      @(posedge clk); #1;
    end
    chk("reach loop2 measure", found, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid rst tero_en", tero_en, 0);
    chk("mid rst busy", busy, 0);
    chk("mid rst cnt_clear", cnt_clear, 0);
    chk("mid rst tero_sel", tero_sel, 0);
    chk("mid rst response", response, 0);
    @(negedge clk);
    reset_n = 1'b1;
    // Fresh counts: 10>20 -> 0, 30>5 -> 1.
    set_counts(10, 20, 30, 5);
    run_scan("post rst", 2'd0, 2'b10, 8'h1B, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
